// File: rtl/ram_port_arbiter.sv
// Arbitrates the single data-RAM port between the CPU memory stage and a DMA master.
// CPU wins by default; a starvation counter forces DMA bursts of up to BURST_MAX beats.
module ram_port_arbiter #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WAIT   = 4,
  parameter int BURST_MAX  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cpu_req,
  input  logic [DATA_WIDTH/8-1:0]   cpu_we,
  input  logic [ADDR_WIDTH-1:0]     cpu_addr,
  input  logic [DATA_WIDTH-1:0]     cpu_wdata,
  output logic [DATA_WIDTH-1:0]     cpu_rdata,
  output logic                      cpu_stall,
  input  logic                      dma_valid,
  output logic                      dma_ready,
  input  logic                      dma_last,
  input  logic [DATA_WIDTH/8-1:0]   dma_we,
  input  logic [ADDR_WIDTH-1:0]     dma_addr,
  input  logic [DATA_WIDTH-1:0]     dma_wdata,
  output logic                      dma_rvalid,
  output logic [DATA_WIDTH-1:0]     dma_rdata,
  output logic [DATA_WIDTH/8-1:0]   ram_we_a,
  output logic [ADDR_WIDTH-1:0]     ram_addr_a,
  output logic [DATA_WIDTH-1:0]     ram_wdata_a,
  input  logic [DATA_WIDTH-1:0]     ram_rdata_a
);

  localparam int BW = DATA_WIDTH / 8;
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam int CW = $clog2(BURST_MAX + 1);

  typedef enum logic [0:0] {
    S_CPU   = 1'b0,
    S_BURST = 1'b1
  } state_t;

  state_t          state_q;
  logic [WW-1:0]   wait_cnt_q;
  logic [CW-1:0]   beat_cnt_q;
  logic            dma_rvalid_q;

  logic            starve_s;
  logic            grant_s;
  logic            dma_rd_s;
  logic [CW-1:0]   beat_nxt_s;

  // Grant decision and port mux; the RAM never sees a write while in reset.
  always_comb begin
    starve_s    = (wait_cnt_q == WW'(MAX_WAIT));
    beat_nxt_s  = beat_cnt_q + {{(CW-1){1'b0}}, 1'b1};
    dma_rd_s    = (dma_we == {BW{1'b0}});
    grant_s     = 1'b0;
    ram_we_a    = {BW{1'b0}};
    ram_addr_a  = cpu_addr;
    ram_wdata_a = cpu_wdata;
    if (rst) begin
      grant_s = 1'b0;
    end else if (state_q == S_BURST) begin
      grant_s = dma_valid;
    end else begin
      grant_s = dma_valid & (~cpu_req | starve_s);
    end
    if (grant_s) begin
      ram_we_a    = dma_we;
      ram_addr_a  = dma_addr;
      ram_wdata_a = dma_wdata;
    end else if (cpu_req & ~rst) begin
      ram_we_a    = cpu_we;
      ram_addr_a  = cpu_addr;
      ram_wdata_a = cpu_wdata;
    end else begin
      ram_we_a    = {BW{1'b0}};
    end
  end

  assign dma_ready  = grant_s;
  assign cpu_stall  = cpu_req & grant_s;
  assign dma_rvalid = dma_rvalid_q;
  assign dma_rdata  = ram_rdata_a;
  assign cpu_rdata  = ram_rdata_a;

  // Ownership FSM with starvation and burst-length counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_CPU;
      wait_cnt_q   <= {WW{1'b0}};
      beat_cnt_q   <= {CW{1'b0}};
      dma_rvalid_q <= 1'b0;
    end else begin
      dma_rvalid_q <= grant_s & dma_rd_s;
      if (grant_s | ~dma_valid) begin
        wait_cnt_q <= {WW{1'b0}};
      end else if (!starve_s) begin
        wait_cnt_q <= wait_cnt_q + {{(WW-1){1'b0}}, 1'b1};
      end else begin
        wait_cnt_q <= wait_cnt_q;
      end
      case (state_q)
        S_CPU: begin
          if (grant_s & ~dma_last & (BURST_MAX > 1)) begin
            state_q    <= S_BURST;
            beat_cnt_q <= {{(CW-1){1'b0}}, 1'b1};
          end else begin
            state_q    <= S_CPU;
            beat_cnt_q <= {CW{1'b0}};
          end
        end
        S_BURST: begin
          // A bubble hands the port back to the CPU for that very cycle.
          if (~dma_valid | dma_last | (beat_nxt_s == CW'(BURST_MAX))) begin
            state_q    <= S_CPU;
            beat_cnt_q <= {CW{1'b0}};
          end else begin
            state_q    <= S_BURST;
            beat_cnt_q <= beat_nxt_s;
          end
        end
        default: begin
          state_q    <= S_CPU;
          beat_cnt_q <= {CW{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Randomized self-checking bench for ram_port_arbiter with a behavioural
// arbitration model and a shadow memory for read-data prediction.
module tb_ram_port_arbiter;
  localparam int AW = 9;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int MAX_WAIT = 4;
  localparam int BURST_MAX = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          cpu_req;
  logic [BW-1:0] cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_stall;
  logic          dma_valid;
  logic          dma_ready;
  logic          dma_last;
  logic [BW-1:0] dma_we;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic          dma_rvalid;
  logic [DW-1:0] dma_rdata;
  logic [BW-1:0] ram_we_a;
  logic [AW-1:0] ram_addr_a;
  logic [DW-1:0] ram_wdata_a;
  logic [DW-1:0] ram_rdata_a;

  ram_port_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(MAX_WAIT), .BURST_MAX(BURST_MAX)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_valid(dma_valid), .dma_ready(dma_ready), .dma_last(dma_last), .dma_we(dma_we),
    .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .ram_we_a(ram_we_a), .ram_addr_a(ram_addr_a), .ram_wdata_a(ram_wdata_a),
    .ram_rdata_a(ram_rdata_a)
  );

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w,
                                          input logic [DW-1:0] new_w,
                                          input logic [BW-1:0] be);
    logic [DW-1:0] r;
    r = old_w;
    for (int b = 0; b < BW; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  // Behavioural RAM: registered read, byte-enabled write.
  logic [DW-1:0] ram_mem [0:511];
  always @(posedge clk) begin
    ram_rdata_a <= ram_mem[ram_addr_a];
    if (ram_we_a != 4'h0) ram_mem[ram_addr_a] <= merge(ram_mem[ram_addr_a], ram_wdata_a, ram_we_a);
  end

  // Reference model state.
  logic [DW-1:0] exp_mem [0:511];
  int            denied;
  int            beats;
  bit            in_burst;
  bit            exp_rvalid;
  bit            exp_crd;
  logic [DW-1:0] exp_drdata;
  logic [DW-1:0] exp_crdata;
  int            n_cmp;
  int            n_err;
  logic          obs_ready;
  logic          obs_stall;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_in(input logic r, input logic creq, input logic [BW-1:0] cwe,
                        input logic [AW-1:0] ca, input logic [DW-1:0] cwd,
                        input logic dv, input logic dl, input logic [BW-1:0] dwe,
                        input logic [AW-1:0] da, input logic [DW-1:0] dwd);
    rst = r; cpu_req = creq; cpu_we = cwe; cpu_addr = ca; cpu_wdata = cwd;
    dma_valid = dv; dma_last = dl; dma_we = dwe; dma_addr = da; dma_wdata = dwd;
  endtask

  // Checks the current cycle against the model, advances the model, steps one clock.
  task automatic cycle();
    bit            g;
    logic [BW-1:0] exp_we;
    #1;
    g = !rst && dma_valid && (in_burst || !cpu_req || denied >= MAX_WAIT);
    obs_ready = dma_ready;
    obs_stall = cpu_stall;
    check_eq("dma_ready", dma_ready, g);
    check_eq("cpu_stall", cpu_stall, cpu_req && g);
    exp_we = g ? dma_we : ((!rst && cpu_req) ? cpu_we : 4'h0);
    check_eq("ram_we_a", ram_we_a, exp_we);
    if (g) begin
      check_eq("ram_addr_dma", ram_addr_a, dma_addr);
      if (dma_we != 4'h0) check_eq("ram_wdata_dma", ram_wdata_a, dma_wdata);
    end else if (!rst && cpu_req) begin
      check_eq("ram_addr_cpu", ram_addr_a, cpu_addr);
      if (cpu_we != 4'h0) check_eq("ram_wdata_cpu", ram_wdata_a, cpu_wdata);
    end
    check_eq("dma_rvalid", dma_rvalid, exp_rvalid);
    if (exp_rvalid) check_eq("dma_rdata", dma_rdata, exp_drdata);
    if (exp_crd) check_eq("cpu_rdata", cpu_rdata, exp_crdata);

    if (rst) begin
      denied = 0; beats = 0; in_burst = 0; exp_rvalid = 0; exp_crd = 0;
    end else begin
      exp_rvalid = g && (dma_we == 4'h0);
      exp_drdata = exp_mem[dma_addr];
      exp_crd    = !g && cpu_req && (cpu_we == 4'h0);
      exp_crdata = exp_mem[cpu_addr];
      if (g) exp_mem[dma_addr] = merge(exp_mem[dma_addr], dma_wdata, dma_we);
      else if (cpu_req) exp_mem[cpu_addr] = merge(exp_mem[cpu_addr], cpu_wdata, cpu_we);
      if (g || !dma_valid) denied = 0;
      else if (denied < MAX_WAIT) denied++;
      if (in_burst) begin
        if (!dma_valid) begin
          in_burst = 0; beats = 0;
        end else begin
          beats++;
          if (dma_last || beats >= BURST_MAX) begin in_burst = 0; beats = 0; end
        end
      end else if (g && !dma_last && BURST_MAX > 1) begin
        in_burst = 1; beats = 1;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int cnt;
    n_cmp = 0; n_err = 0;
    denied = 0; beats = 0; in_burst = 0; exp_rvalid = 0; exp_crd = 0;
    exp_drdata = '0; exp_crdata = '0; ram_rdata_a = '0;
    for (int i = 0; i < 512; i++) begin ram_mem[i] = '0; exp_mem[i] = '0; end
    set_in(1'b1, 1'b1, 4'h0, 9'h000, 32'h0, 1'b1, 1'b0, 4'h0, 9'h000, 32'h0);
    @(negedge clk);
    cycle();
    cycle();
    check_eq("rst_ready", obs_ready, 1'b0);
    check_eq("rst_stall", obs_stall, 1'b0);

    // CPU write then read back.
    set_in(1'b0, 1'b1, 4'hF, 9'h010, 32'hDEADBEEF, 1'b0, 1'b0, 4'h0, 9'h000, 32'h0);
    cycle();
    check_eq("t1_stall_wr", obs_stall, 1'b0);
    set_in(1'b0, 1'b1, 4'h0, 9'h010, 32'h0, 1'b0, 1'b0, 4'h0, 9'h000, 32'h0);
    cycle();
    check_eq("t1_stall_rd", obs_stall, 1'b0);
    check_eq("t1_rdata", cpu_rdata, 32'hDEADBEEF);

    // Idle-port single DMA write.
    set_in(1'b0, 1'b0, 4'h0, 9'h000, 32'h0, 1'b1, 1'b1, 4'hF, 9'h020, 32'h12345678);
    cycle();
    check_eq("t2_ready", obs_ready, 1'b1);

    // Starvation, forced grant, then burst cap.
    set_in(1'b0, 1'b1, 4'h0, 9'h000, 32'h0, 1'b1, 1'b0, 4'h0, 9'h010, 32'h0);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (obs_ready) break;
      cnt++;
    end
    check_eq("t3_denied", cnt, MAX_WAIT);
    check_eq("t3_stall", obs_stall, 1'b1);
    check_eq("t5_rvalid", dma_rvalid, 1'b1);
    check_eq("t5_rdata", dma_rdata, 32'hDEADBEEF);
    cnt = 1;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (!obs_ready) break;
      cnt++;
    end
    check_eq("t4_beats", cnt, BURST_MAX);
    check_eq("t4_cpu_back", obs_stall, 1'b0);

    // Bubble mid-burst returns the port to the CPU.
    set_in(1'b0, 1'b0, 4'h0, 9'h000, 32'h0, 1'b1, 1'b0, 4'h0, 9'h030, 32'h0);
    cycle();
    set_in(1'b0, 1'b1, 4'hF, 9'h040, 32'hCAFEF00D, 1'b0, 1'b0, 4'h0, 9'h030, 32'h0);
    cycle();
    check_eq("t6_bubble_stall", obs_stall, 1'b0);
    set_in(1'b0, 1'b1, 4'h0, 9'h040, 32'h0, 1'b1, 1'b0, 4'h0, 9'h030, 32'h0);
    cycle();
    check_eq("t6_after_bubble", obs_ready, 1'b0);

    // Reset in the middle of a burst.
    set_in(1'b0, 1'b0, 4'h0, 9'h000, 32'h0, 1'b1, 1'b0, 4'h0, 9'h030, 32'h0);
    cycle();
    cycle();
    set_in(1'b1, 1'b1, 4'h0, 9'h000, 32'h0, 1'b1, 1'b0, 4'h0, 9'h030, 32'h0);
    cycle();
    check_eq("t6_rst_ready", obs_ready, 1'b0);
    check_eq("t6_rst_stall", obs_stall, 1'b0);
    check_eq("t6_rst_rvalid", dma_rvalid, 1'b0);
    set_in(1'b0, 1'b1, 4'h0, 9'h000, 32'h0, 1'b1, 1'b0, 4'h0, 9'h030, 32'h0);
    cycle();
    check_eq("t6_post_rst", obs_ready, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      set_in(($urandom_range(0, 99) == 0),
             ($urandom_range(0, 9) < 6),
             ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0,
             9'($urandom_range(0, 15)), $urandom,
             ($urandom_range(0, 1) == 1),
             ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0,
             9'($urandom_range(0, 15)), $urandom);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
